// File: rtl/riscv_issue_scoreboard.sv
// Single-entry issue stage with a 32-register pending-write scoreboard.
// Holds one decoded instruction and withholds issue on RAW/WAW hazards.
module riscv_issue_scoreboard #(
    parameter int NWB   = 2,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [31:0]        in_inst,
    input  logic               in_uses_ra,
    input  logic               in_uses_rb,
    input  logic               in_wr,
    input  logic [4:0]         in_rd,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [31:0]        out_inst,
    output logic               out_wr,
    output logic [4:0]         out_rd,
    input  logic [NWB-1:0]     wb_val,
    input  logic [5*NWB-1:0]   wb_rd,
    input  logic               flush,
    output logic               busy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               err
);

    logic        entry_val;
    logic [31:0] ent_inst;
    logic        ent_uses_ra;
    logic        ent_uses_rb;
    logic        ent_wr;
    logic [4:0]  ent_rd;

    logic [31:0] pending;
    logic [31:0] wb_mask;
    logic [31:0] pend_eff;
    logic [31:0] set_mask;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        hazard;
    logic        fire;
    logic        accept;
    logic        wb_err;

    always_comb begin
        wb_mask = '0;
        for (int unsigned k = 0; k < NWB; k++) begin
            if (wb_val[k]) begin
                wb_mask[wb_rd[5*k +: 5]] = 1'b1;
            end
        end
        wb_mask[0] = 1'b0;
    end

    // Writeback to a register with no registered pending bit, or two ports
    // retiring the same register, indicates a broken pipeline downstream.
    always_comb begin
        wb_err = 1'b0;
        for (int unsigned k = 0; k < NWB; k++) begin
            if (wb_val[k] && wb_rd[5*k +: 5] != 5'd0) begin
                if (!pending[wb_rd[5*k +: 5]]) begin
                    wb_err = 1'b1;
                end
                for (int unsigned j = k + 1; j < NWB; j++) begin
                    if (wb_val[j] && wb_rd[5*j +: 5] == wb_rd[5*k +: 5]) begin
                        wb_err = 1'b1;
                    end
                end
            end
        end
    end

    assign pend_eff = pending & ~wb_mask;
    assign ra       = ent_inst[24:20];
    assign rb       = ent_inst[19:15];

    assign hazard = (ent_uses_ra && ra != 5'd0 && pend_eff[ra])
                  | (ent_uses_rb && rb != 5'd0 && pend_eff[rb])
                  | (ent_wr && ent_rd != 5'd0 && pend_eff[ent_rd]);

    assign out_val = entry_val & ~hazard & ~flush;
    assign fire    = out_val & out_rdy;
    assign in_rdy  = ~flush & (~entry_val | fire);
    assign accept  = in_val & in_rdy;

    assign out_inst = ent_inst;
    assign out_wr   = ent_wr;
    assign out_rd   = ent_rd;
    assign busy     = |pending;

    always_comb begin
        set_mask = '0;
        if (fire && ent_wr && ent_rd != 5'd0) begin
            set_mask[ent_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_val   <= 1'b0;
            ent_inst    <= '0;
            ent_uses_ra <= 1'b0;
            ent_uses_rb <= 1'b0;
            ent_wr      <= 1'b0;
            ent_rd      <= '0;
        end else if (flush) begin
            entry_val <= 1'b0;
        end else if (accept) begin
            entry_val   <= 1'b1;
            ent_inst    <= in_inst;
            ent_uses_ra <= in_uses_ra;
            ent_uses_rb <= in_uses_rb;
            ent_wr      <= in_wr;
            ent_rd      <= in_rd;
        end else if (fire) begin
            entry_val <= 1'b0;
        end
    end

    // Set is ORed after the clear so a same-cycle retire/re-issue keeps the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            pending <= pend_eff | set_mask;
            if (entry_val && hazard && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (wb_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_issue_scoreboard.sv
// Randomized + directed bench for riscv_issue_scoreboard with a queue-based
// scoreboard fed by an array-level reference model.
module tb_riscv_issue_scoreboard;

    localparam int     NWB   = 2;
    localparam int     CNT_W = 5;
    localparam longint SMAX  = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_val;
    logic             in_rdy;
    logic [31:0]      in_inst;
    logic             in_uses_ra;
    logic             in_uses_rb;
    logic             in_wr;
    logic [4:0]       in_rd;
    logic             out_val;
    logic             out_rdy;
    logic [31:0]      out_inst;
    logic             out_wr;
    logic [4:0]       out_rd;
    logic [NWB-1:0]   wb_val;
    logic [5*NWB-1:0] wb_rd;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic             err;

    always #5 clk = ~clk;

    riscv_issue_scoreboard #(.NWB(NWB), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_inst(in_inst),
        .in_uses_ra(in_uses_ra), .in_uses_rb(in_uses_rb),
        .in_wr(in_wr), .in_rd(in_rd),
        .out_val(out_val), .out_rdy(out_rdy), .out_inst(out_inst),
        .out_wr(out_wr), .out_rd(out_rd),
        .wb_val(wb_val), .wb_rd(wb_rd), .flush(flush),
        .busy(busy), .stall_cnt(stall_cnt), .err(err)
    );

    typedef struct {
        bit          in_rdy;
        bit          out_val;
        bit          busy;
        bit          err;
        longint      stall;
        bit          chk_inst;
        logic [31:0] inst;
        bit          wr;
        int          rd;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        bit          wr;
        int          rd;
    } iss_t;

    exp_t sq[$];
    iss_t iq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: current (m_*) and next (n_*) for the held entry and regfile pending flags.
    bit          m_val, n_val;
    logic [31:0] m_inst, n_inst;
    bit          m_ua, m_ub, m_wr, n_ua, n_ub, n_wr;
    int          m_rd, n_rd;
    bit          m_pend[32];
    bit          n_pend[32];
    longint      m_stall, n_stall;
    bit          m_err, n_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit wbhit(input int r);
        for (int k = 0; k < NWB; k++)
            if (wb_val[k] && int'(wb_rd[5*k +: 5]) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_now(input int r);
        return r != 0 && m_pend[r] && !wbhit(r);
    endfunction

    function automatic logic [31:0] mk(input int ra, input int rb, input logic [31:0] fill);
        logic [31:0] w;
        w = fill;
        w[24:20] = 5'(ra);
        w[19:15] = 5'(rb);
        return w;
    endfunction

    task automatic step(input bit rst, input bit iv, input logic [31:0] inst,
                        input bit ua, input bit ub, input bit wr, input int rd,
                        input bit ordy, input bit [1:0] wbv, input int w0, input int w1,
                        input bit fl);
        bit   haz, ov, fire, ir, acc, any;
        exp_t e;
        iss_t f;
        @(posedge clk);
        m_val = n_val; m_inst = n_inst; m_ua = n_ua; m_ub = n_ub; m_wr = n_wr; m_rd = n_rd;
        m_pend = n_pend; m_stall = n_stall; m_err = n_err;
        #1;
        reset = rst; in_val = iv; in_inst = inst; in_uses_ra = ua; in_uses_rb = ub;
        in_wr = wr; in_rd = 5'(rd); out_rdy = ordy; wb_val = wbv;
        wb_rd = {5'(w1), 5'(w0)}; flush = fl;
        if (rst) begin
            m_val = 0; m_stall = 0; m_err = 0;
            foreach (m_pend[i]) m_pend[i] = 0;
        end
        haz  = (m_ua && pend_now(int'(m_inst[24:20]))) || (m_ub && pend_now(int'(m_inst[19:15])))
            || (m_wr && pend_now(m_rd));
        ov   = m_val && !haz && !fl;
        fire = ov && ordy;
        ir   = !fl && (!m_val || fire);
        acc  = iv && ir;
        any  = 0;
        foreach (m_pend[i]) any |= m_pend[i];
        e = '{in_rdy: ir, out_val: ov, busy: any, err: m_err, stall: m_stall,
              chk_inst: m_val, inst: m_inst, wr: m_wr, rd: m_rd};
        sq.push_back(e);
        if (fire) begin
            f = '{inst: m_inst, wr: m_wr, rd: m_rd};
            iq.push_back(f);
        end
        n_pend = m_pend;
        for (int r = 1; r < 32; r++) if (wbhit(r)) n_pend[r] = 0;
        if (fire && m_wr && m_rd != 0) n_pend[m_rd] = 1;
        n_err = m_err;
        if (wbv[0] && w0 != 0 && !m_pend[w0]) n_err = 1;
        if (wbv[1] && w1 != 0 && !m_pend[w1]) n_err = 1;
        if (wbv == 2'b11 && w0 == w1 && w0 != 0) n_err = 1;
        n_stall = (m_val && haz && !fl) ? ((m_stall < SMAX) ? m_stall + 1 : SMAX) : m_stall;
        n_val = m_val; n_inst = m_inst; n_ua = m_ua; n_ub = m_ub; n_wr = m_wr; n_rd = m_rd;
        if (fl) n_val = 0;
        else if (acc) begin
            n_val = 1; n_inst = inst; n_ua = ua; n_ub = ub; n_wr = wr; n_rd = rd;
        end else if (fire) n_val = 0;
        if (rst) begin
            n_val = 0; n_stall = 0; n_err = 0;
            foreach (n_pend[i]) n_pend[i] = 0;
        end
    endtask

    task automatic idle(input bit ordy, input bit [1:0] wbv, input int w0, input int w1, input bit fl);
        step(0, 0, 32'h0, 0, 0, 0, 0, ordy, wbv, w0, w1, fl);
    endtask

    initial begin : monitor
        exp_t e;
        iss_t f;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("in_rdy", in_rdy, e.in_rdy);
                chk("out_val", out_val, e.out_val);
                chk("busy", busy, e.busy);
                chk("err", err, e.err);
                chk("stall_cnt", stall_cnt, e.stall);
                if (e.chk_inst) begin
                    chk("out_inst", out_inst, e.inst);
                    chk("out_wr", out_wr, e.wr);
                    chk("out_rd", out_rd, e.rd);
                end
                if (out_val === 1'b1 && out_rdy === 1'b1) begin
                    if (iq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_issue: got inst %0h expected no issue at %0t", out_inst, $time);
                    end else begin
                        f = iq.pop_front();
                        chk("issue_inst", out_inst, f.inst);
                        chk("issue_rd", out_rd, f.rd);
                    end
                end
            end
        end
    end

    initial begin : driver
        int plist[$];
        bit [1:0] wbv;
        int w[2];
        reset = 1; in_val = 0; in_inst = '0; in_uses_ra = 0; in_uses_rb = 0; in_wr = 0;
        in_rd = '0; out_rdy = 0; wb_val = '0; wb_rd = '0; flush = 0;

        // RAW on x5, released by same-cycle writeback
        step(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
        idle(1, 2'b00, 0, 0, 0);
        step(0, 1, mk(0, 0, 32'h0000_0033), 0, 0, 1, 5, 1, 2'b00, 0, 0, 0);
        step(0, 1, mk(5, 0, 32'h0000_0013), 1, 0, 0, 0, 1, 2'b00, 0, 0, 0);
        repeat (3) idle(1, 2'b00, 0, 0, 0);
        idle(1, 2'b01, 5, 0, 0);
        // WAW on x7: clear and set in the same cycle
        step(0, 1, mk(0, 0, 32'h0000_00b3), 0, 0, 1, 7, 1, 2'b00, 0, 0, 0);
        step(0, 1, mk(0, 0, 32'h0000_01b3), 0, 0, 1, 7, 1, 2'b00, 0, 0, 0);
        repeat (2) idle(1, 2'b00, 0, 0, 0);
        idle(1, 2'b10, 0, 7, 0);
        idle(1, 2'b00, 0, 0, 0);
        // x0 destination/source never hazards; wb to x0 is harmless
        step(0, 1, mk(0, 0, 32'h0000_0233), 1, 1, 1, 0, 1, 2'b00, 0, 0, 0);
        step(0, 1, mk(0, 0, 32'h0000_0333), 1, 0, 0, 0, 1, 2'b01, 0, 0, 0);
        idle(1, 2'b11, 0, 0, 0);
        // backpressure, then flush dropping a same-cycle offer
        step(0, 1, mk(1, 2, 32'h0000_0433), 1, 1, 1, 3, 0, 2'b00, 0, 0, 0);
        repeat (3) idle(0, 2'b00, 0, 0, 0);
        step(0, 1, mk(0, 0, 32'h0000_0533), 0, 0, 1, 6, 0, 2'b00, 0, 0, 1);
        idle(1, 2'b00, 0, 0, 0);
        // error cases and reset in the middle of a stall
        idle(1, 2'b01, 9, 0, 0);
        repeat (2) idle(1, 2'b00, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
        step(0, 1, mk(0, 0, 32'h0000_0633), 0, 0, 1, 4, 1, 2'b00, 0, 0, 0);
        step(0, 1, mk(4, 0, 32'h0000_0733), 1, 0, 0, 0, 1, 2'b00, 0, 0, 0);
        idle(1, 2'b00, 0, 0, 0);
        idle(1, 2'b11, 4, 4, 0);
        repeat (2) idle(1, 2'b00, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
        idle(1, 2'b00, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            plist.delete();
            for (int r = 1; r < 32; r++) if (n_pend[r]) plist.push_back(r);
            wbv = 2'b00;
            w[0] = 0;
            w[1] = 0;
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 99) < 30) begin
                    if ($urandom_range(0, 99) < 3) begin
                        wbv[k] = 1; w[k] = $urandom_range(0, 9);
                    end else if (plist.size() > 0) begin
                        wbv[k] = 1; w[k] = plist[$urandom_range(0, plist.size() - 1)];
                        if (k == 1 && wbv[0] && w[0] == w[1] && $urandom_range(0, 99) >= 2) wbv[1] = 0;
                    end
                end
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 70,
                 mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                 $urandom_range(0, 99) < 80, wbv, w[0], w[1], $urandom_range(0, 15) == 0);
        end

        idle(1, 2'b00, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("issue_queue_drained", iq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_issue_scoreboard.md
Name: riscv_issue_scoreboard

Overview:
Single-entry issue stage between decode and execute. Holds one decoded instruction and extracts its source register fields. It tracks per-register pending writes in a 32-bit scoreboard and withholds issue on RAW/WAW hazards until writeback clears them. It also exports a stall counter and a sticky protocol-error flag for the logging/trace infrastructure.

Parameters:
NWB, 2, number of writeback ports clearing scoreboard bits (1..4)
CNT_W, 32, width of the hazard stall counter (saturating)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
in_val  input  1  decode offers an instruction
in_rdy  output  1  issue stage accepts the offered instruction this cycle
in_inst  input  32  instruction word; ra=in_inst[24:20], rb=in_inst[19:15]
in_uses_ra  input  1  instruction reads ra
in_uses_rb  input  1  instruction reads rb
in_wr  input  1  instruction writes a destination
in_rd  input  5  destination register (encoding-dependent, supplied by decode)
out_val  output  1  instruction issued to execute
out_rdy  input  1  execute accepts
out_inst  output  32  held instruction word
out_wr  output  1  held instruction writes rd
out_rd  output  5  held destination
wb_val  input  NWB  per-port writeback valid
wb_rd  input  5*NWB  per-port writeback register, port k at [5k+4:5k]
flush  input  1  discard held instruction (branch redirect)
busy  output  1  any scoreboard bit set
stall_cnt  output  CNT_W  cycles lost to hazards
err  output  1  sticky protocol error

Behaviour:
- Reset (async, immediate): entry_val=0, pending=0, stall_cnt=0, err=0. Outputs then read out_val=0, busy=0, and in_rdy=1 (when flush=0).
- Register x0 is never pending. Writes to rd=0 do not set bits. ra/rb/rd equal to 0 never cause a hazard.
- wb_mask = OR over ports k of wb_val[k] ? onehot(wb_rd[k]) : 0, with bit 0 forced to 0.
- pend_eff = pending & ~wb_mask. Writeback clears are visible to the hazard check in the same cycle (zero-cycle bypass).
- hazard = (uses_ra & ra!=0 & pend_eff[ra]) | (uses_rb & rb!=0 & pend_eff[rb]) | (wr & rd!=0 & pend_eff[rd]). These are evaluated on the held entry.
- out_val = entry_val & ~hazard & ~flush. fire = out_val & out_rdy.
- in_rdy = ~flush & (~entry_val | fire). Accept = in_val & in_rdy. This allows back-to-back issue at one instruction per cycle.
- Entry update:
  - on flush: entry_val<=0;
  - else on accept: load fields, entry_val<=1;
  - else on fire: entry_val<=0.
- Scoreboard next = (pending & ~wb_mask) | (fire & out_wr & out_rd!=0 ? onehot(out_rd) : 0).
  - If the same register is cleared and set in one cycle, set wins.
- Flush does not touch pending bits, because in-flight instructions still write back. A flush in the same cycle as in_val drops the offered instruction (in_rdy=0).
- stall_cnt increments when entry_val & hazard & ~flush. It saturates at all-ones. Backpressure on out_rdy alone is not counted.
- err is set (and held until reset) when either:
  - a wb_val port targets a non-zero register whose pending bit is 0 (after same-cycle set is excluded);
  - two valid ports name the same non-zero register in one cycle.
- busy = |pending (registered bits, not pend_eff).
- out_* fields hold the entry contents and remain stable while out_val=1 and out_rdy=0.

Test Plan:
- Reset then issue ADD writing rd=5 with out_rdy=1: issues the cycle after acceptance, pending[5]=1, busy=1. Next instr reading ra=5 stalls, out_val=0, and stall_cnt counts 1,2,3 per cycle until wb_val[0]=1 with wb_rd=5; it issues that same cycle.
- WAW: pending[7]=1, held instruction writes rd=7 with no sources. It is held until writeback of 7. On the issue cycle wb clears and fire sets bit 7, so pending[7] ends at 1.
- x0 handling: instruction rd=0 issues without setting any bit. Source ra=0 never stalls even with wb_rd=0 pulses, and err stays 0.
- Backpressure then flush: entry held with out_rdy=0 for 3 cycles (stall_cnt unchanged). Asserting flush gives entry_val=0 next cycle, in_val during flush is dropped, and pending bits are unchanged.
- Errors: wb_rd=9 with pending[9]=0 sets err=1 and it stays 1. Ports 0 and 1 both naming rd=4 in the same cycle also set err. Asserting reset mid-stall clears err, pending, and stall_cnt immediately.
